// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO family.
// Imported by fifo_wrap_ptr and fifo_sync_flags.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pointer width for a FIFO of the given depth.
    function automatic int addr_w(input int depth);
        return clog2_min1(depth);
    endfunction

    // Occupancy counter width: must hold 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer counter; wraps DEPTH-1 -> 0 so any depth works.
// Ports: clock, reset (async, active-high), inc, ptr.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO, any depth >= 2, standard or FWFT read, with count,
// almost flags and sticky overflow/underflow. Ports: clock, reset,
// wr_en/wr_data, rd_en, clr_err -> rd_data/rd_valid, full, empty,
// almost_full, almost_empty, count, overflow, underflow.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic                         clr_err,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    // Acceptance uses registered flags: no pass-through on full/empty.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Flags come from the next-state count so they move with count.
    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        // A new error in the same cycle as clr_err wins.
        ovf_d   = (ovf_q & ~clr_err) | (wr_en & full_q);
        udf_d   = (udf_q & ~clr_err) | (rd_en & empty_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  rd_valid_q, rd_valid_d;

            // Dropped reads leave rd_data untouched.
            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_acc;
                if (rd_acc) begin
                    rd_data_d = mem[rd_ptr];
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Single-clock synchronous FIFO. It is the parametrised successor to the basic normal-mode FIFO, adding the following:
- Any depth ≥ 2, not just powers of two.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Occupancy count output.
- Programmable almost-full and almost-empty flags.
- Sticky overflow and underflow error flags.
It sits between producer and consumer logic in the same clock domain, as a general buffering primitive.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries; any integer ≥ 2.
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- wr_en, input, 1, write request.
- wr_data, input, DATA_WIDTH, write data.
- rd_en, input, 1, read request (FWFT: pop/acknowledge of the head word).
- clr_err, input, 1, synchronous clear of the sticky error flags.
- rd_data, output, DATA_WIDTH, read data.
- rd_valid, output, 1, rd_data is valid.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count ≥ AF_THRESH.
- almost_empty, output, 1, count ≤ AE_THRESH.
- count, output, CNT_W = $clog2(DEPTH+1), current occupancy.
- overflow, output, 1, sticky: a write was attempted while full.
- underflow, output, 1, sticky: a read was attempted while empty.

Behaviour:
- Clock and reset:
  - Clock is clock.
  - Reset is reset: asynchronous, active-high.
  - Reset values: pointers 0, count 0, rd_data 0, rd_valid 0, empty 1, full 0, almost_full 0, almost_empty 1 (AE_THRESH ≥ 0), overflow 0, underflow 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data immediately; the first write after reset deassertion lands at entry 0.
- Handshake and acceptance:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
  - Flags are evaluated on the registered count at the start of the cycle.
  - A write while full is dropped, even if a read is accepted in the same cycle; there is no pass-through.
  - A read while empty is dropped, even if a write is accepted in the same cycle.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W = $clog2(DEPTH) bits wide.
  - Each increments on acceptance and wraps from DEPTH-1 to 0; this supports non-power-of-two depths.
- Count:
  - count += 1 on wr_acc only.
  - count -= 1 on rd_acc only.
  - count is unchanged when both or neither are accepted.
  - full, empty, almost_full and almost_empty are registered, derived from the next-state count, so they change in the same edge as count.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the next edge.
  - Otherwise rd_valid <= 0 and rd_data holds its last value; a dropped read does not update rd_data.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr], read combinationally, and rd_valid = !empty.
  - The head word is visible with no rd_en.
  - rd_en on a valid head consumes it; the next word appears in the following cycle.
  - A word written into an empty FIFO is visible one cycle after the write edge.
- Errors:
  - overflow <= 1 on (wr_en & full).
  - underflow <= 1 on (rd_en & empty).
  - Both flags are sticky until reset or clr_err.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Simultaneous read and write at count 0 < n < DEPTH: both are accepted, count is unchanged, and data order is preserved.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2_min1(n): returns max(1, $clog2(n)).
  - localparam conventions for CNT_W and ADDR_W.
  - FWFT mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
- One sub-module: fifo_wrap_ptr.
  - Parameters: DEPTH, ADDR_W.
  - Ports: clock, reset, inc; output ptr.
  - Function: modulo-DEPTH pointer counter, instantiated twice (write and read).

Test Plan:
- DEPTH=5, FWFT=0, AF_THRESH=4, AE_THRESH=1:
  - Write 0x11..0x15 → after the 4th write almost_full=1; after the 5th full=1, count=5.
  - Read 5 → rd_data 0x11..0x15 each 1 cycle after rd_en with rd_valid=1; then empty=1, count=0.
  - Pointers wrap 4→0 correctly.
- Full FIFO, wr_en=1 & rd_en=1 in the same cycle → read accepted, write dropped, count=4, overflow=1.
- Then clr_err=1 for one cycle → overflow=0.
- Empty FIFO, rd_en=1 with wr_en=1 (data 0xA5) → read dropped, underflow=1, rd_valid stays 0, count=1.
- The next read returns 0xA5.
- FWFT=1, DEPTH=16:
  - Write 0x3C into the empty FIFO → next cycle rd_valid=1, rd_data=0x3C with no rd_en.
  - Write 0x3D, then assert rd_en → following cycle rd_data=0x3D.
- Steady simultaneous read/write at count=8 for 20 cycles → count stays 8, output sequence equals input sequence delayed by 8 words.
- Assert reset mid-stream at count=7 → same-cycle (async) outputs: count=0, empty=1, almost_empty=1, rd_valid=0, overflow/underflow=0.
